latch_q_debounce: RTL and testbench
===================================

// Module: latch_q_debounce
// PURPOSE
//   Downstream consumer of the level-sensitive D latch output (q). The latch
//   output is asynchronous to clk, so this block synchronises it into the clk
//   domain and debounces it with a fixed stability window.
//   It presents a clean level, one-cycle rise/fall pulses and a saturating
//   transition counter to later logic.
// PARAMETERS
//   SYNC_STAGES    2   synchroniser depth, in flops; legal values >= 2
//   STABLE_CYCLES  4   consecutive equal synced samples needed to accept a change; >= 1
//   CNT_W          8   width of toggle_count
// PORTS
//   clk           in   1      single clock; every flop is rising-edge
//   reset         in   1      synchronous, active-high
//   q_in          in   1      latch q; asynchronous level
//   clr_count     in   1      synchronous clear of toggle_count
//   level         out  1      debounced, synchronised copy of q_in
//   rise          out  1      1-cycle pulse when level goes 0->1
//   fall          out  1      1-cycle pulse when level goes 1->0
//   toggle_count  out  CNT_W  number of accepted transitions; saturates
// BEHAVIOUR
//   - Reset (reset=1 at a rising clk edge), taking effect on that edge:
//     sync flops=0, state=STABLE_LOW, check counter=0, level=0, rise=0, fall=0,
//     toggle_count=0.
//   - Reset mid-check abandons the check. It does not generate a pulse.
//   - Synchroniser: s = last flop of a SYNC_STAGES-deep shift of q_in.
//     Only s feeds the FSM; q_in never feeds it directly.
//   - FSM states and transitions (cnt is the check counter, range 0..STABLE_CYCLES):
//       STABLE_LOW:  s=1 -> CHECK_HIGH, cnt=1. If STABLE_CYCLES=1, go directly to
//                    STABLE_HIGH instead.
//       CHECK_HIGH:  s=0 -> STABLE_LOW, cnt=0, no pulse.
//                    s=1 -> cnt+1. When cnt+1 == STABLE_CYCLES -> STABLE_HIGH.
//       STABLE_HIGH / CHECK_LOW: mirror of the two states above, with the
//                    polarity inverted.
//   - On the edge that enters STABLE_HIGH: level<=1 and rise<=1.
//     On the edge that enters STABLE_LOW from CHECK_LOW: level<=0 and fall<=1.
//     rise and fall are 0 on every other edge. They are never both 1.
//   - Latency: q_in changes and then holds. level/rise/fall update on the
//     (SYNC_STAGES+STABLE_CYCLES)-th rising edge, counting the first edge that
//     samples the new value as edge 1. With the defaults this is edge 6.
//   - Glitch filtering: any pulse on s shorter than STABLE_CYCLES samples
//     produces no level change, no pulse and no count.
//   - toggle_count: increments on each cycle where rise or fall is set.
//     Saturates at 2^CNT_W-1; it never wraps.
//   - clr_count=1 clears toggle_count to 0 on the next edge.
//     If clr_count coincides with an increment edge, toggle_count <= 1, so the
//     event is not lost.
//   - All outputs are registered. There are no combinational paths from inputs
//     to outputs.
//   - The upstream latch powers up with q=X. The system asserts the latch enable
//     with d=0 while reset is held for >= SYNC_STAGES cycles, so q_in is known
//     before reset is released.
// TESTING
//   - Reset: hold reset 3 cycles with q_in=0 -> level=0, rise=0, fall=0,
//     toggle_count=0 on every cycle.
//   - Clean rise (defaults): q_in 0->1 before edge 1, then held -> level=1 and
//     rise=1 on edge 6 only, toggle_count=1; rise=0 on edge 7.
//   - Glitch: q_in high for 3 cycles, then low -> level stays 0, no rise,
//     toggle_count unchanged.
//     Same test with a 4-cycle high -> rise occurs, followed by a fall pulse
//     6 edges after the drop.
//   - Saturation: CNT_W=2, drive 5 accepted transitions -> toggle_count reads
//     1,2,3,3,3.
//     Assert clr_count on the same edge as the 5th pulse -> toggle_count=1.
//   - Reset mid-check: q_in rises; assert reset at edge 4 -> level=0, no rise.
//     With q_in still high, release reset -> rise occurs 6 edges after release.
//   - Randomised: 100 random {d,ena} pairs drive the latch, with the latch
//     output on q_in. The bench checks every cycle against a cycle-accurate
//     model: level, rise, fall and toggle_count must match.

Source files
------------

// File: rtl/latch_q_debounce.sv
// Synchronises the asynchronous latch output q_in into the clk domain, debounces it with a
// fixed stability window and reports a clean level, rise/fall pulses and a saturating
// count of accepted transitions.
module latch_q_debounce #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             q_in,
  input  logic             clr_count,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] toggle_count
);

  // Check counter must hold 0..STABLE_CYCLES.
  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  // cnt_q == StableLast means this sample completes the window.
  localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [CNT_W-1:0] CountMax  = '1;
  localparam logic [CNT_W-1:0] CountOne  = CNT_W'(1);

  typedef enum logic [1:0] {
    StStableLow,
    StCheckHigh,
    StStableHigh,
    StCheckLow
  } state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    level_q, level_d;
  logic                    rise_q, rise_d;
  logic                    fall_q, fall_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    s;

  // Shift q_in through the synchroniser; only the last stage is used downstream.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], q_in};
    s      = sync_q[SYNC_STAGES-1];
  end

  // Debounce FSM next state: a change is accepted after STABLE_CYCLES equal samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      StStableLow: begin
        if (s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = StStableHigh;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = StCheckHigh;
            cnt_d   = CntOne;
          end
        end
      end
      StCheckHigh: begin
        if (!s) begin
          state_d = StStableLow;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StStableHigh;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StStableHigh: begin
        if (!s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = StStableLow;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = StCheckLow;
            cnt_d   = CntOne;
          end
        end
      end
      StCheckLow: begin
        if (s) begin
          state_d = StStableHigh;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StStableLow;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
    endcase
  end

  // Transition counter tracks the pulse being registered this edge; a clear that coincides
  // with a pulse keeps that pulse as the first count.
  always_comb begin
    count_d = count_q;
    if (rise_d || fall_d) begin
      if (clr_count) begin
        count_d = CountOne;
      end else if (count_q != CountMax) begin
        count_d = count_q + CountOne;
      end
    end else if (clr_count) begin
      count_d = '0;
    end
  end

  // All state and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= StStableLow;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
    end
  end

  assign level        = level_q;
  assign rise         = rise_q;
  assign fall         = fall_q;
  assign toggle_count = count_q;

endmodule

// File: tb/tb_latch_q_debounce.sv
// Bench for latch_q_debounce: table-driven reset/rise vectors, hand-written corner
// sequences and randomised latch stimulus, all checked every cycle against a window model.
module tb_latch_q_debounce;

  localparam int unsigned Sync   = 2;
  localparam int unsigned Stable = 4;

  logic       clk;
  logic       reset;
  logic       q_in;
  logic       clr_count;
  logic       level_a, rise_a, fall_a;
  logic [7:0] count_a;
  logic       level_b, rise_b, fall_b;
  logic [1:0] count_b;

  int checks = 0;
  int errors = 0;

  latch_q_debounce #(.SYNC_STAGES(Sync), .STABLE_CYCLES(Stable), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .q_in         (q_in),
    .clr_count    (clr_count),
    .level        (level_a),
    .rise         (rise_a),
    .fall         (fall_a),
    .toggle_count (count_a)
  );

  latch_q_debounce #(.SYNC_STAGES(Sync), .STABLE_CYCLES(Stable), .CNT_W(2)) dut_n (
    .clk          (clk),
    .reset        (reset),
    .q_in         (q_in),
    .clr_count    (clr_count),
    .level        (level_b),
    .rise         (rise_b),
    .fall         (fall_b),
    .toggle_count (count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: q_in delayed SYNC samples, then a level flips once the last
  // STABLE delayed samples all disagree with it.
  int m_pipe[$];
  int m_hist[$];
  int m_level, m_rise, m_fall, m_cnt8, m_cnt2;

  function automatic int count_next(int c, int maxv, int pulse, int clr);
    if (pulse != 0) return (clr != 0) ? 1 : ((c == maxv) ? c : c + 1);
    if (clr != 0) return 0;
    return c;
  endfunction

  function automatic void model_reset();
    m_pipe.delete();
    m_hist.delete();
    for (int i = 0; i < Sync; i++) m_pipe.push_back(0);
    for (int i = 0; i < Stable; i++) m_hist.push_back(0);
    m_level = 0; m_rise = 0; m_fall = 0; m_cnt8 = 0; m_cnt2 = 0;
  endfunction

  function automatic void model_step(int rst, int q, int clr);
    int s;
    int all_diff;
    if (rst != 0) begin
      model_reset();
      return;
    end
    s = m_pipe.pop_back();
    m_pipe.push_front(q);
    void'(m_hist.pop_back());
    m_hist.push_front(s);
    all_diff = 1;
    foreach (m_hist[i]) if (m_hist[i] == m_level) all_diff = 0;
    m_rise = 0;
    m_fall = 0;
    if (all_diff != 0) begin
      m_level = 1 - m_level;
      if (m_level != 0) m_rise = 1; else m_fall = 1;
    end
    m_cnt8 = count_next(m_cnt8, 255, m_rise + m_fall, clr);
    m_cnt2 = count_next(m_cnt2, 3, m_rise + m_fall, clr);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: step the model on the edge, compare both instances 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step(int'(reset), int'(q_in), int'(clr_count));
    #1;
    check("model_level", 32'(level_a), 32'(m_level));
    check("model_rise", 32'(rise_a), 32'(m_rise));
    check("model_fall", 32'(fall_a), 32'(m_fall));
    check("model_count8", 32'(count_a), 32'(m_cnt8));
    check("model_count2", 32'(count_b), 32'(m_cnt2));
    check("pulse_exclusive", 32'(rise_a & fall_a), 32'd0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    bit rst;
    bit q;
    bit clr;
    bit lvl;
    bit rs;
    bit fl;
    int cnt;
  } vec_t;

  vec_t tbl[11];
  int   sat_exp[5];
  int   base;
  bit   lq;
  bit   d;
  bit   ena;
  int   hold;

  initial begin
    model_reset();
    reset     = 1'b1;
    q_in      = 1'b0;
    clr_count = 1'b0;

    // Three reset cycles, then a clean rise held for eight edges.
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 1, 0, 1, 1, 0, 1};
    tbl[9]  = '{0, 1, 0, 1, 0, 0, 1};
    tbl[10] = '{0, 1, 0, 1, 0, 0, 1};
    sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3; sat_exp[4] = 3;

    for (int i = 0; i < 11; i++) begin
      reset     = tbl[i].rst;
      q_in      = tbl[i].q;
      clr_count = tbl[i].clr;
      tick();
      check("tbl_level", 32'(level_a), 32'(tbl[i].lvl));
      check("tbl_rise", 32'(rise_a), 32'(tbl[i].rs));
      check("tbl_fall", 32'(fall_a), 32'(tbl[i].fl));
      check("tbl_count", 32'(count_a), 32'(tbl[i].cnt));
    end

    // Drop back low: fall on the sixth edge.
    q_in = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check("drop_fall", 32'(fall_a), 32'(e == 6));
    end
    check("drop_count", 32'(count_a), 32'd2);

    // Three-cycle glitch is filtered.
    base = 2;
    q_in = 1'b1;
    ticks(3);
    q_in = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      check("glitch3_level", 32'(level_a), 32'd0);
      check("glitch3_rise", 32'(rise_a), 32'd0);
    end
    check("glitch3_count", 32'(count_a), 32'(base));

    // Four-cycle pulse is accepted: rise on edge 6, fall six edges after the drop.
    q_in = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      if (e == 5) q_in = 1'b0;
      tick();
      check("pulse4_rise", 32'(rise_a), 32'(e == 6));
      check("pulse4_fall", 32'(fall_a), 32'(e == 10));
    end
    check("pulse4_count", 32'(count_a), 32'd4);

    // Reset mid-check abandons the pending rise.
    q_in = 1'b1;
    ticks(3);
    reset = 1'b1;
    for (int e = 4; e <= 5; e++) begin
      tick();
      check("midrst_level", 32'(level_a), 32'd0);
      check("midrst_rise", 32'(rise_a), 32'd0);
      check("midrst_count", 32'(count_a), 32'd0);
    end
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check("postrst_rise", 32'(rise_a), 32'(e == 6));
      check("postrst_level", 32'(level_a), 32'(e >= 6));
    end
    q_in = 1'b0;
    ticks(8);

    // Saturation on the 2-bit counter.
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      q_in = ~q_in;
      ticks(8);
      check("sat_count2", 32'(count_b), 32'(sat_exp[k]));
    end
    q_in = 1'b0;
    ticks(8);

    // Clear coinciding with the fifth pulse keeps that pulse.
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      q_in = ~q_in;
      ticks(8);
    end
    check("preclr_count2", 32'(count_b), 32'd3);
    q_in = 1'b1;
    ticks(5);
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check("clr_rise", 32'(rise_a), 32'd1);
    check("clr_count2", 32'(count_b), 32'd1);
    check("clr_count8", 32'(count_a), 32'd1);
    tick();
    check("clr_hold", 32'(count_a), 32'd1);

    // Randomised latch drive; the latch is reset to 0 while reset is held.
    lq    = 1'b0;
    q_in  = lq;
    reset = 1'b1;
    ticks(3);
    reset = 1'b0;
    for (int p = 0; p < 100; p++) begin
      d   = 1'($urandom_range(0, 1));
      ena = 1'($urandom_range(0, 1));
      if (ena) lq = d;
      q_in      = lq;
      clr_count = ($urandom_range(0, 15) == 0);
      hold      = $urandom_range(1, 8);
      tick();
      clr_count = 1'b0;
      ticks(hold - 1);
    end
    ticks(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
